tpu_mem_arbiter: RTL and testbench

TPU_MEM_ARBITER -- requirements
Module: tpu_mem_arbiter

---
 rtl/soc_pkg.sv | 27 ++
 rtl/tpu_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_tpu_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_pkg
// Description : Shared types for the SoC memory arbiter. Holds the arbiter
//               FSM state encoding, the requester identity encoding and a
//               small helper that returns the opposite requester.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_TPU = 1'b1
    } req_t;

    function automatic req_t other_req(input req_t r);
        return (r == REQ_CPU) ? REQ_TPU : REQ_CPU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tpu_mem_arbiter
// Description : Two-port round-robin arbiter sharing one external
//               single-port SRAM between the CPU (PicoRV32 native bus) and
//               the TPU DMA engine. Each transaction runs IDLE -> ISSUE ->
//               RESP, giving a fixed request-to-ready latency of two cycles.
// Ports       : clk, rst_n (async, active-low)
//               cpu_valid/addr/wdata/wstrb -> cpu_ready, cpu_rdata
//               tpu_valid/addr/wdata/wstrb -> tpu_ready, tpu_rdata
//               mem_en, mem_we, mem_addr, mem_wdata -> SRAM, mem_rdata <- SRAM
//               addr_err: one-cycle pulse with ready for an out-of-range access
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_mem_arbiter
    import soc_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int CPU_FIRST = 1,
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_valid,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,

    input  logic          tpu_valid,
    input  logic [31:0]   tpu_addr,
    input  logic [31:0]   tpu_wdata,
    input  logic [3:0]    tpu_wstrb,
    output logic          tpu_ready,
    output logic [31:0]   tpu_rdata,

    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic          addr_err
);

    localparam logic [29:0] c_MEM_WORDS = 30'(MEM_WORDS);
    // Pretending the opposite port was granted last makes the preferred
    // port win the first tie after reset.
    localparam req_t        c_LAST_RST  = (CPU_FIRST != 0) ? REQ_TPU : REQ_CPU;

    arb_state_t    r_state;
    req_t          r_grant;
    req_t          r_last;
    logic          r_is_read;
    logic          r_err;
    logic          r_cpu_ready;
    logic          r_tpu_ready;
    logic [31:0]   r_cpu_rdata;
    logic [31:0]   r_tpu_rdata;
    logic          r_mem_en;
    logic [3:0]    r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_addr_err;

    req_t          w_grant;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_sel_wstrb;
    logic          w_in_range;
    logic [31:0]   w_resp_rdata;
    logic          w_unused;

    // Byte lanes are selected by wstrb, so the low address bits carry no
    // information for a word-wide SRAM.
    assign w_unused = ^{cpu_addr[1:0], tpu_addr[1:0]};

    // Round-robin: on a tie the port not granted last wins; a lone requester
    // always wins.
    always_comb begin
        w_grant = REQ_CPU;
        if (cpu_valid && tpu_valid) begin
            w_grant = other_req(r_last);
        end else if (tpu_valid) begin
            w_grant = REQ_TPU;
        end
    end

    assign w_sel_addr  = (w_grant == REQ_TPU) ? tpu_addr  : cpu_addr;
    assign w_sel_wdata = (w_grant == REQ_TPU) ? tpu_wdata : cpu_wdata;
    assign w_sel_wstrb = (w_grant == REQ_TPU) ? tpu_wstrb : cpu_wstrb;
    assign w_in_range  = (w_sel_addr[31:2] < c_MEM_WORDS);

    // SRAM read data arrives in RESP, the same cycle ready is shown, so the
    // response data is passed straight through while ready is high.
    assign w_resp_rdata = (r_is_read && !r_err) ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= REQ_CPU;
            r_last      <= c_LAST_RST;
            r_is_read   <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_ready <= 1'b0;
            r_tpu_ready <= 1'b0;
            r_cpu_rdata <= 32'd0;
            r_tpu_rdata <= 32'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_addr_err  <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_cpu_ready <= 1'b0;
            r_tpu_ready <= 1'b0;
            r_addr_err  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'd0;

            case (r_state)
                IDLE: begin
                    if (cpu_valid || tpu_valid) begin
                        // The SRAM command registers double as the payload
                        // latch; later payload changes are ignored.
                        r_grant     <= w_grant;
                        r_last      <= w_grant;
                        r_is_read   <= (w_sel_wstrb == 4'd0);
                        r_err       <= !w_in_range;
                        r_mem_en    <= w_in_range;
                        r_mem_we    <= w_in_range ? w_sel_wstrb : 4'd0;
                        r_mem_addr  <= w_sel_addr[AW+1:2];
                        r_mem_wdata <= w_sel_wdata;
                        r_state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_cpu_ready <= (r_grant == REQ_CPU);
                    r_tpu_ready <= (r_grant == REQ_TPU);
                    r_addr_err  <= r_err;
                    r_state     <= RESP;
                end

                RESP: begin
                    // Capture the response so rdata holds it afterwards.
                    if (r_grant == REQ_CPU) begin
                        r_cpu_rdata <= w_resp_rdata;
                    end else begin
                        r_tpu_rdata <= w_resp_rdata;
                    end
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign tpu_ready = r_tpu_ready;
    assign cpu_rdata = r_cpu_ready ? w_resp_rdata : r_cpu_rdata;
    assign tpu_rdata = r_tpu_ready ? w_resp_rdata : r_tpu_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_tpu_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tpu_mem_arbiter
// Description : Scoreboard bench for tpu_mem_arbiter. Stimulus tasks push
//               expected responses and SRAM accesses; monitors pop and
//               compare whenever the DUT shows ready or mem_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_mem_arbiter;

    localparam int MEM_WORDS = 256;
    localparam int AW        = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_valid = 1'b0, tpu_valid = 1'b0;
    logic [31:0]   cpu_addr = '0, cpu_wdata = '0, tpu_addr = '0, tpu_wdata = '0;
    logic [3:0]    cpu_wstrb = '0, tpu_wstrb = '0;
    logic          cpu_ready, tpu_ready, mem_en, addr_err;
    logic [31:0]   cpu_rdata, tpu_rdata, mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    tpu_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .CPU_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .tpu_valid(tpu_valid), .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata),
        .tpu_wstrb(tpu_wstrb), .tpu_ready(tpu_ready), .tpu_rdata(tpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    // ---------------- SRAM model: byte-write, one-cycle read ----------------
    logic [31:0] sram [MEM_WORDS];
    logic [31:0] sram_w;
    initial for (int i = 0; i < MEM_WORDS; i++) sram[i] = 32'd0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'd0) begin
                sram_w = sram[mem_addr];
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) sram_w[8*b +: 8] = mem_wdata[8*b +: 8];
                sram[mem_addr] <= sram_w;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { bit port; logic [31:0] rdata; bit err; int cyc; } rsp_t;
    typedef struct { logic [3:0] we; logic [AW-1:0] addr; logic [31:0] wdata; } acc_t;
    rsp_t rsp_q[$];
    acc_t acc_q[$];
    rsp_t rsp_e;
    acc_t acc_e;
    logic [31:0] hold_cpu = '0, hold_tpu = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event, required none (t=%0t)", name, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_cpu = '0;
            hold_tpu = '0;
        end else begin
            if (cpu_ready || tpu_ready) begin
                check("ready_overlap", {31'd0, cpu_ready & tpu_ready}, 32'd0);
                if (rsp_q.size() == 0) begin
                    flag("unexpected_ready");
                end else begin
                    rsp_e = rsp_q.pop_front();
                    check("rsp_port", {31'd0, tpu_ready}, {31'd0, rsp_e.port});
                    check("rsp_rdata", rsp_e.port ? tpu_rdata : cpu_rdata, rsp_e.rdata);
                    check("rsp_addr_err", {31'd0, addr_err}, {31'd0, rsp_e.err});
                    check("rsp_cycle", cyc, rsp_e.cyc);
                    if (rsp_e.port) begin
                        check("cpu_rdata_hold", cpu_rdata, hold_cpu);
                        hold_tpu = rsp_e.rdata;
                    end else begin
                        check("tpu_rdata_hold", tpu_rdata, hold_tpu);
                        hold_cpu = rsp_e.rdata;
                    end
                end
            end else if (addr_err) begin
                flag("addr_err_without_ready");
            end
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    flag("unexpected_mem_en");
                end else begin
                    acc_e = acc_q.pop_front();
                    check("mem_we", {28'd0, mem_we}, {28'd0, acc_e.we});
                    check("mem_addr", {24'd0, mem_addr}, {24'd0, acc_e.addr});
                    check("mem_wdata", mem_wdata, acc_e.wdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit port, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (port == 1'b0) begin
            cpu_valid = v; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
        end else begin
            tpu_valid = v; tpu_addr = a; tpu_wdata = d; tpu_wstrb = s;
        end
    endtask

    function automatic logic [AW-1:0] waddr(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // One isolated transaction; arbiter is idle when this is called.
    task automatic do_req(input bit port, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_rdata,
                          input bit exp_err, input bit drop_early);
        int n;
        @(negedge clk);
        rsp_q.push_back('{port, exp_rdata, exp_err, cyc + 2});
        if (!exp_err) acc_q.push_back('{s, waddr(a), d});
        drive(port, 1'b1, a, d, s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop_early && n == 1) drive(port, 1'b0, 32'd0, 32'd0, 4'd0);
        end while (!(port ? tpu_ready : cpu_ready) && n < 10);
        if (n >= 10) flag("ready_timeout");
        drive(port, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    logic [31:0] st_addr  [2][4];
    logic [31:0] st_wdata [2][4];
    logic [3:0]  st_wstrb [2][4];
    logic [31:0] st_rdata [2][4];

    task automatic stream(input bit port);
        int n;
        for (int i = 0; i < 4; i++) begin
            drive(port, 1'b1, st_addr[port][i], st_wdata[port][i], st_wstrb[port][i]);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(port ? tpu_ready : cpu_ready) && n < 20);
            if (n >= 20) flag("stream_timeout");
        end
        drive(port, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int base;
    initial begin
        // Reset state
        #1;
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_tpu_ready", {31'd0, tpu_ready}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_tpu_rdata", tpu_rdata, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Contention straight after reset: CPU first, then strict alternation.
        st_addr[0]  = '{32'h20, 32'h20, 32'h24, 32'h24};
        st_wdata[0] = '{32'h11111111, 32'h0, 32'hA5A5A5A5, 32'h0};
        st_wstrb[0] = '{4'hF, 4'h0, 4'h3, 4'h0};
        st_rdata[0] = '{32'h0, 32'h11111111, 32'h0, 32'h0000A5A5};
        st_addr[1]  = '{32'h40, 32'h40, 32'h44, 32'h44};
        st_wdata[1] = '{32'h22222222, 32'h0, 32'hCAFEF00D, 32'h0};
        st_wstrb[1] = '{4'hF, 4'h0, 4'hF, 4'h0};
        st_rdata[1] = '{32'h0, 32'h22222222, 32'h0, 32'hCAFEF00D};
        @(negedge clk);
        base = cyc;
        for (int k = 0; k < 8; k++) begin
            rsp_q.push_back('{k[0], st_rdata[k%2][k/2], 1'b0, base + 2 + 3*k});
            acc_q.push_back('{st_wstrb[k%2][k/2], waddr(st_addr[k%2][k/2]), st_wdata[k%2][k/2]});
        end
        fork
            stream(1'b0);
            stream(1'b1);
        join

        // Full-word write then read back
        do_req(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        // Byte-lane merge
        do_req(1'b1, 32'h30, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h30, 32'h0000AB00, 4'h2, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 32'h30, 32'h0, 4'h0, 32'h1122AB44, 1'b0, 1'b0);
        // Out of range: first word past the end, and a write further out
        do_req(1'b1, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        do_req(1'b0, 32'h8000_0000, 32'h55555555, 4'hF, 32'h0, 1'b1, 1'b0);
        // Last in-range word
        do_req(1'b0, 32'h3FC, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 32'h3FC, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1'b0);
        // Valid dropped early still completes
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Reset during ISSUE
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h50, 32'h99999999, 4'hF);
        @(posedge clk);
        #1;
        check("issue_mem_en", {31'd0, mem_en}, 32'd1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("midrst_mem_we", {28'd0, mem_we}, 32'd0);
        check("midrst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_cpu_rdata", cpu_rdata, 32'd0);
        check("midrst_tpu_rdata", tpu_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        // Aborted write never reached memory; serviced on first edge after release
        do_req(1'b0, 32'h50, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("rsp_queue_empty", rsp_q.size(), 32'd0);
        check("acc_queue_empty", acc_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
